divide_controller: RTL

Multi-cycle unsigned 16-bit divider controller for the ALU. It performs restoring division by sequencing one shared `subtract` instance (16-bit, two's-complement a − b) over 16 iterations. It owns the operand registers, the iteration counter and the start/busy/done handshake, and it presents quotient and remainder to the ALU result mux.

---
 rtl/divide_controller.sv | 119 +++++++++++
 1 files changed

// File: rtl/divide_controller.sv
// divide_controller: multi-cycle unsigned 16-bit restoring divider controller.
// It sequences one shared subtract instance over 16 iterations and exposes a
// start/busy/done handshake. The quotient and remainder outputs are registered
// and update only when an operation completes.
//
// Ports:
//   clk          clock; all state updates on the rising edge
//   rst          synchronous, active-high reset
//   start        division request, sampled only in IDLE
//   dividend     unsigned numerator, latched on an accepted start
//   divisor      unsigned denominator, latched on an accepted start
//   busy         high while iterations are in progress
//   done         one-cycle completion pulse
//   quotient     registered quotient, held until the next completion
//   remainder    registered remainder, held until the next completion
//   div_by_zero  set when the last accepted operation had divisor == 0

// subtract: 16-bit two's-complement difference a - b. No borrow output.
module subtract (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] diff
);
  assign diff = a - b;
endmodule

module divide_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic {IDLE, ITER} state_t;

  state_t      state;
  logic [15:0] qReg;
  logic [15:0] rReg;
  logic [15:0] dReg;
  logic [3:0]  count;

  logic [16:0] shifted;
  logic [15:0] subDiff;
  logic        takeSub;
  logic [15:0] nextR;
  logic [15:0] nextQ;

  subtract subInst (
    .a    (shifted[15:0]),
    .b    (dReg),
    .diff (subDiff)
  );

  // When shifted[16] is set the compare always succeeds, and the 16-bit
  // difference is still exact because the true result is below dReg.
  always_comb begin
    shifted = {rReg, qReg[15]};
    takeSub = (shifted >= {1'b0, dReg});
    nextR   = takeSub ? subDiff : shifted[15:0];
    nextQ   = {qReg[14:0], takeSub};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      qReg        <= '0;
      rReg        <= '0;
      dReg        <= '0;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              dReg        <= divisor;
              qReg        <= dividend;
              rReg        <= '0;
              count       <= '0;
              div_by_zero <= 1'b0;
              busy        <= 1'b1;
              state       <= ITER;
            end else begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
            end
          end
        end
        ITER: begin
          qReg  <= nextQ;
          rReg  <= nextR;
          count <= count + 4'd1;
          if (count == 4'd15) begin
            quotient  <= nextQ;
            remainder <= nextR;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
